// File: rtl/adrv9001_rx_axis_packer.sv
// Packs strobe-aligned ADRV9001 RX I/Q words into 32-bit AXI-Stream samples {Q,I}.
// A small FWFT FIFO absorbs backpressure, tlast marks every PKT_LEN samples, and drops are counted.
module adrv9001_rx_axis_packer #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int PKT_LEN    = 256,
  parameter  int CNT_W      = 16,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       i_in,
  input  logic [15:0]       q_in,
  input  logic              valid_in,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              active,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [CNT_W-1:0]  overflow_cnt,
  output logic [LVL_W-1:0]  fifo_level
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0]      PKT_LAST   = 16'(PKT_LEN - 1);

  state_e              state_q, state_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [32:0]         mem [FIFO_DEPTH];

  logic        wr_cand;
  logic        wr_full;
  logic        wr_accept;
  logic        wr_drop;
  logic        wr_tlast;
  logic        rd_pop;
  logic [32:0] head;

  assign wr_full   = (level_q == LEVEL_FULL);
  assign wr_accept = wr_cand & ~wr_full;
  assign wr_drop   = wr_cand & wr_full;
  assign wr_tlast  = (pkt_cnt_q == PKT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!enable)       state_d = ST_IDLE;
        else if (valid_in) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A stop on a packet boundary needs no drain; a stop that completes the packet this cycle neither.
        if (!enable) begin
          if (pkt_cnt_q == '0)            state_d = ST_IDLE;
          else if (wr_accept && wr_tlast) state_d = ST_IDLE;
          else                            state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (wr_accept && wr_tlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    wr_cand = 1'b0;
    active  = 1'b0;
    unique case (state_q)
      ST_ARMED: wr_cand = enable & valid_in;
      ST_RUN: begin
        wr_cand = valid_in & (enable | (pkt_cnt_q != '0));
        active  = 1'b1;
      end
      ST_DRAIN: begin
        wr_cand = valid_in;
        active  = 1'b1;
      end
      default: wr_cand = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet counter, FIFO pointers/level, overflow tracking
  // ---------------------------------------------------------------------------
  assign rd_pop = m_axis_tvalid & m_axis_tready;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (wr_accept) begin
      pkt_cnt_d = wr_tlast ? '0 : pkt_cnt_q + 16'd1;
      wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (wr_accept && !rd_pop)      level_d = level_q + LVL_W'(1);
    else if (!wr_accept && rd_pop) level_d = level_q - LVL_W'(1);
  end

  // A drop in the same cycle as a clear wins: the count restarts at one.
  always_comb begin
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
      ovf_cnt_d  = '0;
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
      if (overflow_clr)     ovf_cnt_d = CNT_W'(1);
      else if (~&ovf_cnt_q) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // NOTE: storage is not reset; an empty level masks stale contents, so a reset-free RAM suffices.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= {wr_tlast, q_in, i_in};
  end

  // FWFT head: outputs are forced to zero while empty so reset leaves tdata/tlast at 0.
  assign head          = mem[rd_ptr_q];
  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[31:0] : 32'd0;
  assign m_axis_tlast  = m_axis_tvalid & head[32];
  assign overflow      = overflow_q;
  assign overflow_cnt  = ovf_cnt_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_adrv9001_rx_axis_packer.sv
// Scoreboard bench for adrv9001_rx_axis_packer: a behavioural model queues expected
// FIFO entries as stimulus is driven; they are popped and compared on each AXIS handshake.
module tb_adrv9001_rx_axis_packer;

  localparam int FIFO_DEPTH = 16;
  localparam int PKT_LEN    = 4;
  localparam int CNT_W      = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [15:0]       i_in = '0;
  logic [15:0]       q_in = '0;
  logic              valid_in = 1'b0;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic              active;
  logic              overflow;
  logic              overflow_clr = 1'b0;
  logic [CNT_W-1:0]  overflow_cnt;
  logic [LVL_W-1:0]  fifo_level;

  // Second instance with single-sample packets, sharing all inputs.
  logic [31:0]       p1_tdata;
  logic              p1_tvalid;
  logic              p1_tlast;
  logic              p1_active;
  logic              p1_overflow;
  logic [CNT_W-1:0]  p1_overflow_cnt;
  logic [LVL_W-1:0]  p1_fifo_level;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  logic [32:0] m_q[$];
  logic [32:0] popped[$];
  int          m_st      = M_IDLE;
  int          m_cnt     = 0;
  logic        m_ovf     = 1'b0;
  logic [15:0] m_ovf_cnt = '0;

  always #5 clk = ~clk;

  adrv9001_rx_axis_packer #(
    .FIFO_DEPTH(FIFO_DEPTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .active(active), .overflow(overflow),
    .overflow_clr(overflow_clr), .overflow_cnt(overflow_cnt), .fifo_level(fifo_level)
  );

  adrv9001_rx_axis_packer #(
    .FIFO_DEPTH(FIFO_DEPTH), .PKT_LEN(1), .CNT_W(CNT_W)
  ) u_dut_p1 (
    .clk(clk), .rst(rst), .enable(enable), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
    .m_axis_tdata(p1_tdata), .m_axis_tvalid(p1_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(p1_tlast), .active(p1_active), .overflow(p1_overflow),
    .overflow_clr(overflow_clr), .overflow_cnt(p1_overflow_cnt), .fifo_level(p1_fifo_level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, advance the model on the
  // current inputs, then cross the edge and settle 1 time unit past it.
  task automatic step();
    bit          full, cand, acc, tl, pop;
    int          nxt;
    logic [32:0] exp;
    check("tvalid", m_axis_tvalid, m_q.size() != 0);
    check("fifo_level", fifo_level, m_q.size());
    check("active", active, (m_st == M_RUN) || (m_st == M_DRAIN));
    check("overflow", overflow, m_ovf);
    check("overflow_cnt", overflow_cnt, m_ovf_cnt);
    if (p1_tvalid) check("p1_tlast", p1_tlast, 1'b1);
    if (rst) begin
      @(posedge clk); #1;
      m_q.delete();
      m_st = M_IDLE; m_cnt = 0; m_ovf = 1'b0; m_ovf_cnt = '0;
      return;
    end
    full = (m_q.size() == FIFO_DEPTH);
    pop  = (m_q.size() != 0) && m_axis_tready;
    if (pop) begin
      exp = m_q.pop_front();
      check("tdata", m_axis_tdata, exp[31:0]);
      check("tlast", m_axis_tlast, exp[32]);
      popped.push_back({m_axis_tlast, m_axis_tdata});
    end
    cand = 1'b0;
    nxt  = m_st;
    case (m_st)
      M_IDLE:  if (enable) nxt = M_ARMED;
      M_ARMED: begin
        if (!enable) nxt = M_IDLE;
        else if (valid_in) begin cand = 1'b1; nxt = M_RUN; end
      end
      M_RUN: begin
        if (!enable && m_cnt == 0) nxt = M_IDLE;
        else begin
          cand = valid_in;
          if (!enable) nxt = M_DRAIN;
        end
      end
      default: cand = valid_in;
    endcase
    acc = cand && !full;
    tl  = (m_cnt == PKT_LEN - 1);
    if (acc) begin
      m_q.push_back({tl, q_in, i_in});
      m_cnt = tl ? 0 : m_cnt + 1;
      if (tl && (nxt == M_DRAIN || m_st == M_DRAIN)) nxt = M_IDLE;
    end
    if (cand && full) begin
      m_ovf = 1'b1;
      if (overflow_clr)              m_ovf_cnt = 16'd1;
      else if (m_ovf_cnt != 16'hFFFF) m_ovf_cnt = m_ovf_cnt + 16'd1;
    end else if (overflow_clr) begin
      m_ovf = 1'b0; m_ovf_cnt = '0;
    end
    m_st = nxt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; valid_in = 1'b0; overflow_clr = 1'b0;
    step();
    rst = 1'b0;
    popped.delete();
  endtask

  task automatic arm();
    enable = 1'b1; valid_in = 1'b0;
    step();
  endtask

  task automatic word(input int k);
    i_in = 16'(16'h1000 + k); q_in = 16'(16'h2000 + k); valid_in = 1'b1;
    step();
  endtask

  task automatic idle_drain(input int n);
    enable = 1'b0; valid_in = 1'b0; overflow_clr = 1'b0; m_axis_tready = 1'b1;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    logic [31:0] exp_d;
    int          n;
    @(posedge clk); #1;
    do_reset();
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tlast", m_axis_tlast, 1'b0);

    // 1. Basic capture, tready=1
    m_axis_tready = 1'b1;
    arm();
    for (int k = 0; k < 12; k++) word(k);
    idle_drain(6);
    check("t1_count", popped.size(), 12);
    for (int k = 0; k < 12 && k < popped.size(); k++) begin
      exp_d = {16'(16'h2000 + k), 16'(16'h1000 + k)};
      check("t1_data", popped[k][31:0], exp_d);
      check("t1_tlast", popped[k][32], (k % 4) == 3);
    end
    check("t1_ovf", overflow, 1'b0);

    // 2. Backpressure overflow
    do_reset();
    m_axis_tready = 1'b0;
    arm();
    for (int k = 0; k < 20; k++) word(k);
    check("t2_level", fifo_level, 16);
    check("t2_ovf", overflow, 1'b1);
    check("t2_ovf_cnt", overflow_cnt, 4);
    idle_drain(24);
    check("t2_count", popped.size(), 16);
    for (int k = 0; k < 16 && k < popped.size(); k++)
      check("t2_data", popped[k][15:0], 16'(16'h1000 + k));

    // 3. Clean stop mid-packet: two more writes to tlast, then idle
    do_reset();
    m_axis_tready = 1'b1;
    arm();
    word(0); word(1);
    enable = 1'b0;
    word(2);
    check("t3_active_drain", active, 1'b1);
    word(3);
    check("t3_active_off", active, 1'b0);
    word(4);
    idle_drain(4);
    check("t3_count", popped.size(), 4);
    if (popped.size() == 4) check("t3_tlast", popped[3][32], 1'b1);

    // 4. Arm on valid
    do_reset();
    enable = 1'b1; valid_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t4_no_out", m_axis_tvalid, 1'b0);
    end
    for (int k = 'h50; k < 'h58; k++) word(k);
    idle_drain(6);
    check("t4_count", popped.size(), 8);
    if (popped.size() == 8) begin
      check("t4_first", popped[0][31:0], 32'h2050_1050);
      check("t4_tlast3", popped[3][32], 1'b1);
      check("t4_tlast2", popped[2][32], 1'b0);
    end

    // 5. Clear racing a drop
    do_reset();
    m_axis_tready = 1'b0;
    arm();
    for (int k = 0; k < 23; k++) word(k);
    check("t5_cnt7", overflow_cnt, 7);
    overflow_clr = 1'b1;
    word(23);
    check("t5_race_cnt", overflow_cnt, 1);
    check("t5_race_ovf", overflow, 1'b1);
    valid_in = 1'b0;
    step();
    check("t5_clr_cnt", overflow_cnt, 0);
    check("t5_clr_ovf", overflow, 1'b0);
    idle_drain(20);

    // 6. Reset mid-packet
    do_reset();
    m_axis_tready = 1'b0;
    arm();
    for (int k = 0; k < 9; k++) word(k);
    check("t6_level9", fifo_level, 9);
    check("t6_tvalid1", m_axis_tvalid, 1'b1);
    do_reset();
    check("t6_tvalid0", m_axis_tvalid, 1'b0);
    check("t6_level0", fifo_level, 0);
    check("t6_idle", active, 1'b0);
    m_axis_tready = 1'b1;
    arm();
    for (int k = 'h80; k < 'h88; k++) word(k);
    idle_drain(6);
    n = popped.size();
    check("t6_count", n, 8);
    if (n == 8) begin
      check("t6_first", popped[0][31:0], 32'h2080_1080);
      check("t6_tlast3", popped[3][32], 1'b1);
      check("t6_tlast7", popped[7][32], 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
